// File: rtl/ram_arbiter_pkg.sv
// Shared definitions for the two-port main-RAM arbiter.
// Holds the FSM state encodings and the requester port indices.
package ram_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_RESP   = 2'd2
  } arb_state_e;

  localparam logic PORT_IFETCH = 1'b0;
  localparam logic PORT_DATA   = 1'b1;

  function automatic logic other_port(input logic p);
    return ~p;
  endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the synchronous-read RAM.
// The slave modport is the arbiter's view; the master modport is the core/RAM side.
interface ram_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int MASK_WIDTH = DATA_WIDTH / 8;

  logic                  req0;
  logic                  req1;
  logic                  we0;
  logic                  we1;
  logic [ADDR_WIDTH-1:0] addr0;
  logic [ADDR_WIDTH-1:0] addr1;
  logic [DATA_WIDTH-1:0] wdata0;
  logic [DATA_WIDTH-1:0] wdata1;
  logic [MASK_WIDTH-1:0] wmask0;
  logic [MASK_WIDTH-1:0] wmask1;
  logic                  ack0;
  logic                  ack1;
  logic [DATA_WIDTH-1:0] rdata0;
  logic [DATA_WIDTH-1:0] rdata1;

  logic                  ram_en;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic [MASK_WIDTH-1:0] ram_wmask;
  logic [DATA_WIDTH-1:0] ram_rdata;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, wmask0, wmask1,
    input  ram_rdata,
    output ack0, ack1, rdata0, rdata1,
    output ram_en, ram_we, ram_addr, ram_wdata, ram_wmask
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, wmask0, wmask1,
    output ram_rdata,
    input  ack0, ack1, rdata0, rdata1,
    input  ram_en, ram_we, ram_addr, ram_wdata, ram_wmask
  );

endinterface

// File: rtl/ram_arbiter_rr_pick2.sv
// Two-way round-robin pick used when the arbiter is idle.
// On a tie the port not served most recently wins.
module rr_pick2
  import ram_arbiter_pkg::*;
(
  input  logic req0_i,
  input  logic req1_i,
  input  logic last_i,
  output logic winner_o
);

  always_comb begin
    winner_o = PORT_IFETCH;
    if (req0_i && req1_i) begin
      winner_o = other_port(last_i);
    end else if (req1_i) begin
      winner_o = PORT_DATA;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares the single-port main RAM between instruction fetch (port 0) and load/store (port 1).
// One transaction in flight: ACCESS drives the RAM, RESP acks the owner with the registered read data.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic          sys_clk,
  input  logic          sys_res,
  ram_arbiter_if.slave  bus
);

  localparam int MASK_WIDTH = DATA_WIDTH / 8;

  arb_state_e state_q, state_d;
  logic       owner_q, owner_d;
  logic       last_q, last_d;
  logic       pick;
  logic       other_req;

  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [MASK_WIDTH-1:0] sel_wmask;

  rr_pick2 u_pick (
    .req0_i   (bus.req0),
    .req1_i   (bus.req1),
    .last_i   (last_q),
    .winner_o (pick)
  );

  // last resets to port 1 so that port 0 wins the first tie
  always_ff @(posedge sys_clk or negedge sys_res) begin
    if (!sys_res) begin
      state_q <= ARB_IDLE;
      owner_q <= PORT_IFETCH;
      last_q  <= PORT_DATA;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  assign other_req = (owner_q == PORT_IFETCH) ? bus.req1 : bus.req0;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    case (state_q)
      ARB_IDLE: begin
        if (bus.req0 || bus.req1) begin
          owner_d = pick;
          state_d = ARB_ACCESS;
        end
      end
      ARB_ACCESS: begin
        state_d = ARB_RESP;
      end
      ARB_RESP: begin
        // the owner's own req still belongs to the transaction being acked
        last_d = owner_q;
        if (other_req) begin
          owner_d = other_port(owner_q);
          state_d = ARB_ACCESS;
        end else begin
          state_d = ARB_IDLE;
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  always_comb begin
    sel_we    = bus.we0;
    sel_addr  = bus.addr0;
    sel_wdata = bus.wdata0;
    sel_wmask = bus.wmask0;
    if (owner_q == PORT_DATA) begin
      sel_we    = bus.we1;
      sel_addr  = bus.addr1;
      sel_wdata = bus.wdata1;
      sel_wmask = bus.wmask1;
    end
  end

  assign bus.ram_en    = (state_q == ARB_ACCESS);
  assign bus.ram_we    = bus.ram_en && sel_we;
  assign bus.ram_addr  = sel_addr;
  assign bus.ram_wdata = sel_wdata;
  assign bus.ram_wmask = sel_wmask;

  assign bus.ack0   = (state_q == ARB_RESP) && (owner_q == PORT_IFETCH);
  assign bus.ack1   = (state_q == ARB_RESP) && (owner_q == PORT_DATA);
  assign bus.rdata0 = bus.ram_rdata;
  assign bus.rdata1 = bus.ram_rdata;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural synchronous-read RAM.
// Inputs change and outputs are checked on the falling clock edge.
module tb_ram_arbiter;
  import ram_arbiter_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;

  logic sys_clk;
  logic sys_res;
  int   total;
  int   bad;

  logic [31:0] mem [logic [31:0]];

  ram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .sys_clk (sys_clk),
    .sys_res (sys_res),
    .bus     (bus)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // synchronous-read RAM: read data registered, byte-masked write at the same edge
  always @(posedge sys_clk) begin
    if (bus.ram_en) begin
      logic [31:0] cur;
      cur = mem.exists(bus.ram_addr) ? mem[bus.ram_addr] : 32'h0;
      bus.ram_rdata <= cur;
      if (bus.ram_we) begin
        for (int b = 0; b < 4; b++) begin
          if (bus.ram_wmask[b]) cur[b*8 +: 8] = bus.ram_wdata[b*8 +: 8];
        end
        mem[bus.ram_addr] = cur;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge sys_clk);
  endtask

  task automatic idle_inputs();
    bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0; bus.wmask0 = '0;
    bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0; bus.wmask1 = '0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    sys_res = 1'b0;
    bus.ram_rdata = '0;
    idle_inputs();
    mem[32'h10] = 32'hDEAD_BEEF;
    mem[32'h20] = 32'h1111_1111;
    mem[32'h30] = 32'h5555_5555;

    // reset hold, then release with no requests
    cyc(); cyc();
    chk("rst_outputs", {61'd0, bus.ram_en, bus.ack0, bus.ack1}, 64'd0);
    sys_res = 1'b1;
    for (int k = 0; k < 10; k++) begin
      cyc();
      chk("idle_outputs", {61'd0, bus.ram_en, bus.ack0, bus.ack1}, 64'd0);
      chk("idle_state", {62'd0, dut.state_q}, {62'd0, ARB_IDLE});
    end

    // port 0 read of 0x10
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 32'h10;
    cyc();
    chk("p0rd_ram_en", {63'd0, bus.ram_en}, 64'd1);
    chk("p0rd_ram_we", {63'd0, bus.ram_we}, 64'd0);
    chk("p0rd_ram_addr", {32'd0, bus.ram_addr}, 64'h10);
    chk("p0rd_early_ack", {62'd0, bus.ack0, bus.ack1}, 64'd0);
    cyc();
    chk("p0rd_acks", {62'd0, bus.ack0, bus.ack1}, 64'b10);
    chk("p0rd_rdata", {32'd0, bus.rdata0}, 64'hDEAD_BEEF);
    chk("p0rd_ram_en_resp", {63'd0, bus.ram_en}, 64'd0);
    bus.req0 = 1'b0;
    cyc();
    chk("p0rd_after", {61'd0, bus.ram_en, bus.ack0, bus.ack1}, 64'd0);

    // port 1 masked write then read back
    bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 32'h20;
    bus.wdata1 = 32'hCAFE_F00D; bus.wmask1 = 4'b0011;
    cyc();
    chk("p1wr_en_we", {62'd0, bus.ram_en, bus.ram_we}, 64'b11);
    chk("p1wr_addr", {32'd0, bus.ram_addr}, 64'h20);
    chk("p1wr_wdata", {32'd0, bus.ram_wdata}, 64'hCAFE_F00D);
    chk("p1wr_wmask", {60'd0, bus.ram_wmask}, 64'b0011);
    cyc();
    chk("p1wr_acks", {62'd0, bus.ack0, bus.ack1}, 64'b01);
    chk("p1wr_mem", {32'd0, mem[32'h20]}, 64'h1111_F00D);
    bus.req1 = 1'b0; bus.we1 = 1'b0; bus.wmask1 = 4'b0000;
    cyc();
    bus.req1 = 1'b1;
    cyc();
    chk("p1rd_en_we", {62'd0, bus.ram_en, bus.ram_we}, 64'b10);
    cyc();
    chk("p1rd_acks", {62'd0, bus.ack0, bus.ack1}, 64'b01);
    chk("p1rd_rdata", {32'd0, bus.rdata1}, 64'h1111_F00D);
    bus.req1 = 1'b0;
    cyc();

    // fresh reset, then simultaneous requests: port 0 first, port 1 two cycles later
    sys_res = 1'b0;
    cyc();
    sys_res = 1'b1;
    bus.req0 = 1'b1; bus.addr0 = 32'h10;
    bus.req1 = 1'b1; bus.addr1 = 32'h20;
    cyc();
    chk("tie_access0_addr", {32'd0, bus.ram_addr}, 64'h10);
    cyc();
    chk("tie_first_acks", {62'd0, bus.ack0, bus.ack1}, 64'b10);
    chk("tie_first_rdata", {32'd0, bus.rdata0}, 64'hDEAD_BEEF);
    bus.req0 = 1'b0;
    cyc();
    chk("tie_no_gap_en", {63'd0, bus.ram_en}, 64'd1);
    chk("tie_access1_addr", {32'd0, bus.ram_addr}, 64'h20);
    cyc();
    chk("tie_second_acks", {62'd0, bus.ack0, bus.ack1}, 64'b01);
    chk("tie_second_rdata", {32'd0, bus.rdata1}, 64'h1111_F00D);
    bus.req1 = 1'b0;
    cyc();

    // both held for 20 cycles: acks 0,1,0,1 two cycles apart
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      cyc();
      chk("hold_acks", {62'd0, bus.ack0, bus.ack1},
          {62'd0, (k % 4) == 2, (k % 4) == 0});
      chk("hold_ram_en", {63'd0, bus.ram_en}, {63'd0, (k % 2) == 1});
      if ((k % 4) == 2) chk("hold_rdata0", {32'd0, bus.rdata0}, 64'hDEAD_BEEF);
      if ((k % 4) == 0) chk("hold_rdata1", {32'd0, bus.rdata1}, 64'h1111_F00D);
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    cyc();
    chk("hold_after", {61'd0, bus.ram_en, bus.ack0, bus.ack1}, 64'd0);

    // port 0 alone, then a tie: port 1 now wins
    bus.req0 = 1'b1;
    cyc(); cyc();
    chk("solo0_ack", {62'd0, bus.ack0, bus.ack1}, 64'b10);
    bus.req0 = 1'b0;
    cyc();
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    cyc();
    chk("tie2_access_addr", {32'd0, bus.ram_addr}, 64'h20);
    cyc();
    chk("tie2_first_acks", {62'd0, bus.ack0, bus.ack1}, 64'b01);
    bus.req1 = 1'b0;
    cyc(); cyc();
    chk("tie2_second_acks", {62'd0, bus.ack0, bus.ack1}, 64'b10);
    bus.req0 = 1'b0;
    cyc();

    // reset during ACCESS of a port 1 write aborts it
    bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 32'h30;
    bus.wdata1 = 32'hAAAA_AAAA; bus.wmask1 = 4'b1111;
    cyc();
    chk("abort_access", {62'd0, bus.ram_en, bus.ram_we}, 64'b11);
    sys_res = 1'b0;
    #1;
    chk("abort_async_drop", {60'd0, bus.ram_en, bus.ram_we, bus.ack0, bus.ack1}, 64'd0);
    idle_inputs();
    cyc();
    chk("abort_no_ack", {61'd0, bus.ram_en, bus.ack0, bus.ack1}, 64'd0);
    cyc();
    chk("abort_mem", {32'd0, mem[32'h30]}, 64'h5555_5555);
    sys_res = 1'b1;
    cyc();
    chk("abort_idle_state", {62'd0, dut.state_q}, {62'd0, ARB_IDLE});
    bus.req0 = 1'b1; bus.addr0 = 32'h10;
    bus.req1 = 1'b1; bus.addr1 = 32'h30;
    cyc();
    chk("post_rst_addr", {32'd0, bus.ram_addr}, 64'h10);
    cyc();
    chk("post_rst_acks", {62'd0, bus.ack0, bus.ack1}, 64'b10);
    bus.req0 = 1'b0;
    cyc(); cyc();
    chk("post_rst_acks2", {62'd0, bus.ack0, bus.ack1}, 64'b01);
    chk("post_rst_rdata1", {32'd0, bus.rdata1}, 64'h5555_5555);
    bus.req1 = 1'b0;
    cyc();
    chk("final_idle", {61'd0, bus.ram_en, bus.ack0, bus.ack1}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
